// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: the control
// FSM state encoding and the widened add/subtract helper used by the
// accumulator datapath. WIDTH up to MUL_MAX_W is supported by the helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Widest operand the add/sub helper can serve; callers zero-pad their
    // WIDTH+1-bit values into this container and slice the result back.
    localparam int MUL_MAX_W = 128;

    // Adds or subtracts two containers; only the caller's low WIDTH+1 bits
    // are meaningful, so wrap-around beyond that width is harmless.
    function automatic logic [MUL_MAX_W:0] mul_add_sub(
        input logic [MUL_MAX_W:0] a,
        input logic [MUL_MAX_W:0] b,
        input logic               sub
    );
        logic [MUL_MAX_W:0] res;
        res = sub ? (a - b) : (a + b);
        return res;
    endfunction

endpackage

// File: rtl/mul_acc_shift.sv
// Accumulator datapath of the shift-add multiplier. Holds the captured
// multiplicand and the 2*WIDTH+1-bit accumulator {carry, hi, lo/multiplier}.
// load captures new operands, step performs one add-then-shift iteration.
// With SIGNED_MUL_EN defined a mode input selects radix-2 Booth recoding
// with an arithmetic shift; otherwise only the unsigned path is built.
module mul_acc_shift
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
`ifdef SIGNED_MUL_EN
    input  logic                 mode,
`endif
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH:0]     acc_q, acc_d;
    logic [WIDTH:0]       hi_ext;
    logic [WIDTH:0]       mcand_ext;
    logic [WIDTH:0]       part;
    logic [MUL_MAX_W:0]   a_wide, b_wide, sum_wide;
    logic [2*WIDTH:0]     step_acc;
    logic                 do_op, do_sub, shift_in;
    logic                 unused_sum_hi;
`ifdef SIGNED_MUL_EN
    logic                 q_m1_q, q_m1_d;
    logic                 signed_q, signed_d;
`endif

    // Upper container bits of the widened sum carry no information.
    assign unused_sum_hi = |sum_wide[MUL_MAX_W:WIDTH+1];

    // One iteration: optional add/sub into the upper half, then a 1-bit right shift.
    always_comb begin
        hi_ext    = acc_q[2*WIDTH:WIDTH];
        mcand_ext = {1'b0, mcand_q};
        do_op     = acc_q[0];
        do_sub    = 1'b0;
        shift_in  = 1'b0;
`ifdef SIGNED_MUL_EN
        if (signed_q) begin
            mcand_ext = {mcand_q[WIDTH-1], mcand_q};
            do_op     = acc_q[0] ^ q_m1_q;
            do_sub    = acc_q[0] & ~q_m1_q;
        end
`endif
        a_wide              = '0;
        a_wide[WIDTH:0]     = hi_ext;
        b_wide              = '0;
        b_wide[WIDTH:0]     = mcand_ext;
        sum_wide            = mul_add_sub(a_wide, b_wide, do_sub);
        part                = do_op ? sum_wide[WIDTH:0] : hi_ext;
`ifdef SIGNED_MUL_EN
        if (signed_q) begin
            shift_in = part[WIDTH];
        end
`endif
        step_acc = {shift_in, part, acc_q[WIDTH-1:1]};
        acc_next = step_acc[2*WIDTH-1:0];
    end

    // Next-state selection for the operand and accumulator registers.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
`ifdef SIGNED_MUL_EN
        q_m1_d   = q_m1_q;
        signed_d = signed_q;
`endif
        if (load) begin
            mcand_d = multiplicand;
            acc_d   = {{(WIDTH+1){1'b0}}, multiplier};
`ifdef SIGNED_MUL_EN
            q_m1_d   = 1'b0;
            signed_d = mode;
`endif
        end else if (step) begin
            acc_d = step_acc;
`ifdef SIGNED_MUL_EN
            q_m1_d = acc_q[0];
`endif
        end
    end

    // Datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
`ifdef SIGNED_MUL_EN
            q_m1_q   <= 1'b0;
            signed_q <= 1'b0;
`endif
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
`ifdef SIGNED_MUL_EN
            q_m1_q   <= q_m1_d;
            signed_q <= signed_d;
`endif
        end
    end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Multi-cycle MUL unit: iterative shift-add multiplier with a start/busy/done
// handshake. The FSM, iteration counter, product register and handshake live
// here; the add/shift datapath is in mul_acc_shift.
// Optional feature macro: SIGNED_MUL_EN (Booth signed path via signed_mode).
module seq_shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_e           state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 last;
    logic [2*WIDTH-1:0]   acc_next;

    mul_acc_shift #(
        .WIDTH(WIDTH)
    ) u_acc (
        .clk          (clk),
        .reset        (reset),
        .load         (accept),
        .step         (state_q == RUN),
`ifdef SIGNED_MUL_EN
        .mode         (signed_mode),
`endif
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .acc_next     (acc_next)
    );

`ifndef SIGNED_MUL_EN
    // Without the signed datapath the mode pin has no effect on behaviour.
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
`endif

    // Control FSM: accept start in IDLE/DONE, count WIDTH iterations, latch product.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        product_d = product_q;
        accept    = 1'b0;
        last      = (count_q == LAST_CNT);
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                count_d = count_q + 1'b1;
                if (last) begin
                    state_d   = DONE;
                    product_d = acc_next;
                end
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            count_d = '0;
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed self-checking bench for seq_shift_add_mul (WIDTH=32, plus a
// WIDTH=8 instance when SIGNED_MUL_EN is defined).
// Edge counting: the start-sampling edge is edge 1; done must be seen high
// right after edge 33 (WIDTH+1), with busy high after edges 1..32.
module tb_seq_shift_add_mul;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        signed_mode;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int assert_count = 0;
    int fail_count   = 0;

    seq_shift_add_mul #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

`ifdef SIGNED_MUL_EN
    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] product8;

    seq_shift_add_mul #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start8),
        .multiplicand (a8),
        .multiplier   (b8),
        .signed_mode  (1'b1),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sm);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = sm;
        start        = 1'b1;
    endtask

    // Caller has start=1 set just after an edge; the next edge is the accept edge.
    task automatic waitDone(input int pulse_at, input logic [31:0] pa, input logic [31:0] pb,
                            output int edges, output int busy_cycles,
                            output logic first_done, output logic [63:0] first_product);
        edges       = 0;
        busy_cycles = 0;
        @(posedge clk); #1;
        start         = 1'b0;
        edges         = 1;
        first_done    = done;
        first_product = product;
        if (busy === 1'b1) busy_cycles++;
        while (done !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (busy === 1'b1) busy_cycles++;
            if (edges == pulse_at) begin
                start        = 1'b1;
                multiplicand = pa;
                multiplier   = pb;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    // Full single operation: launch, wait, check product and latency.
    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sm, input logic [63:0] expected);
        int          edges, busy_cycles;
        logic        first_done;
        logic [63:0] first_product;
        applyStimulus(a, b, sm);
        waitDone(0, 32'h0, 32'h0, edges, busy_cycles, first_done, first_product);
        checkOutput({tag, "_product"}, product, expected);
        checkOutput({tag, "_latency"}, 64'(edges), 64'd33);
    endtask

    initial begin
        int          edges, busy_cycles, done_seen;
        logic        first_done;
        logic [63:0] first_product;

        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        signed_mode  = 1'b0;
`ifdef SIGNED_MUL_EN
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_done", {63'd0, done}, 64'd0);
        checkOutput("reset_product", product, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Test 1: 7 x 6 with latency, busy length and pulse width.
        applyStimulus(32'd7, 32'd6, 1'b0);
        waitDone(0, 32'h0, 32'h0, edges, busy_cycles, first_done, first_product);
        checkOutput("t1_product", product, 64'h2A);
        checkOutput("t1_latency", 64'(edges), 64'd33);
        checkOutput("t1_busy_cycles", 64'(busy_cycles), 64'd32);
        @(posedge clk); #1;
        checkOutput("t1_done_width", {63'd0, done}, 64'd0);
        checkOutput("t1_product_hold", product, 64'h2A);

        // Test 2: carry into the accumulator MSB.
        runOp("t2_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;

        // Test 3: zero operands keep the fixed latency.
        runOp("t3_zero_a", 32'h0, 32'h1234_5678, 1'b0, 64'h0);
        @(posedge clk); #1;
        runOp("t3_zero_b", 32'h1234_5678, 32'h0, 1'b0, 64'h0);
        @(posedge clk); #1;

        // Test 4: start pulse mid-RUN is ignored.
        applyStimulus(32'd9, 32'd11, 1'b0);
        waitDone(10, 32'd1000, 32'd1000, edges, busy_cycles, first_done, first_product);
        checkOutput("t4_product", product, 64'd99);
        checkOutput("t4_latency", 64'(edges), 64'd33);
        checkOutput("t4_busy_cycles", 64'(busy_cycles), 64'd32);

        // Test 4b: start held in the DONE cycle is accepted back-to-back.
        applyStimulus(32'h0001_0000, 32'h0001_0001, 1'b0);
        waitDone(0, 32'h0, 32'h0, edges, busy_cycles, first_done, first_product);
        checkOutput("t4b_done_pulse_ends", {63'd0, first_done}, 64'd0);
        checkOutput("t4b_product_held_at_accept", first_product, 64'd99);
        checkOutput("t4b_product", product, 64'h0000_0001_0001_0000);
        checkOutput("t4b_latency", 64'(edges), 64'd33);
        checkOutput("t4b_busy_cycles", 64'(busy_cycles), 64'd32);
        @(posedge clk); #1;

        // Test 5: asynchronous reset during iteration 10 abandons the operation.
        applyStimulus(32'h55, 32'h66, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t5_busy_before_reset", {63'd0, busy}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("t5_reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("t5_reset_done", {63'd0, done}, 64'd0);
        checkOutput("t5_reset_product", product, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        checkOutput("t5_no_done", 64'(done_seen), 64'd0);
        runOp("t5_after_reset", 32'd3, 32'd5, 1'b0, 64'd15);
        @(posedge clk); #1;

`ifdef SIGNED_MUL_EN
        // Test 6: Booth signed path.
        runOp("t6_neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        @(posedge clk); #1;
        runOp("t6_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        @(posedge clk); #1;
        a8     = 8'h80;
        b8     = 8'h7F;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges  = 1;
        while (done8 !== 1'b1 && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("t6_w8_product", {48'd0, product8}, 64'hC080);
        checkOutput("t6_w8_latency", 64'(edges), 64'd9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
